// File: rtl/digital_lock_param.sv
// -----------------------------------------------------------------------------
// digital_lock_param
//
// Parametrised code-lock core. Consumes single-cycle button-event pulses from
// the debouncer/edge-detector front end and checks a CODE_LEN-digit code over
// NUM_BUTTONS buttons. The core adds three features:
//   - a lockout after MAX_TRIES consecutive failed attempts,
//   - an inter-digit idle timeout,
//   - reprogramming of the code while unlocked.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset; restores DEFAULT_CODE
//   button     press pulses, one clk wide per press; one-hot = digit,
//              multi-hot = invalid digit, zero = no event
//   relock     pulse; re-arm the lock from UNLOCKED (aborts PROGRAM)
//   prog       pulse; enter PROGRAM from UNLOCKED
//   unlocked   high only in UNLOCKED
//   lockout    high only in LOCKOUT
//   state      LOCKED=0, ENTRY=1, UNLOCKED=2, PROGRAM=3, LOCKOUT=4
//   digit_cnt  digits accepted in the current ENTRY/PROGRAM sequence
//   fail_cnt   consecutive failed attempts (saturates at MAX_TRIES)
//   led        status code for the seven-segment controller; 0..4 follow the
//              state encoding, 5 = program committed (one clk)
// -----------------------------------------------------------------------------
module digital_lock_param #(
    parameter int NUM_BUTTONS    = 4,
    parameter int CODE_LEN       = 4,
    parameter logic [CODE_LEN*((NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1)-1:0]
                  DEFAULT_CODE   = {2'd3, 2'd2, 2'd1, 2'd0},
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 50000000,
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_BUTTONS-1:0]             button,
    input  logic                               relock,
    input  logic                               prog,
    output logic                               unlocked,
    output logic                               lockout,
    output logic [2:0]                         state,
    output logic [$clog2(CODE_LEN+1)-1:0]      digit_cnt,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt,
    output logic [3:0]                         led
);

    localparam int IDX_W   = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
    localparam int CODE_W  = CODE_LEN * IDX_W;
    localparam int CNT_W   = $clog2(CODE_LEN + 1);
    localparam int FAIL_W  = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX = (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES
                                                               : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [3:0] LED_COMMIT = 4'd5;

    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_PROGRAM  = 3'd3,
        ST_LOCKOUT  = 3'd4
    } state_t;

    // Registered state
    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [FAIL_W-1:0]   fail_q;
    logic [TMR_W-1:0]    tmr_q;
    logic                mis_q;
    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   shadow_q;

    // Next-state values
    state_t              state_n;
    logic [CNT_W-1:0]    cnt_n;
    logic [FAIL_W-1:0]   fail_n;
    logic [TMR_W-1:0]    tmr_n;
    logic                mis_n;
    logic [CODE_W-1:0]   code_n;
    logic [CODE_W-1:0]   shadow_n;
    logic                commit;

    // Event decode
    logic                any_event;
    logic                one_hot;
    logic [IDX_W-1:0]    digit_val;

    // Code-compare helpers
    logic [CNT_W-1:0]    pos;
    logic [IDX_W-1:0]    expected_digit;
    logic                digit_bad;
    logic                mismatch_acc;
    logic                last_digit;
    logic                idle_expired;
    logic                lock_done;

    // -------------------------------------------------------------------------
    // Button event decode. For multi-hot input digit_val is meaningless, but
    // it is never used in that case because one_hot forces a mismatch/abort.
    // -------------------------------------------------------------------------
    always_comb begin
        any_event = |button;
        one_hot   = $onehot(button);
        digit_val = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (button[i]) digit_val = IDX_W'(i);
        end
    end

    // -------------------------------------------------------------------------
    // Compare helpers. The first digit is taken while still in LOCKED, so
    // position and the running mismatch flag restart from zero there. This
    // also makes CODE_LEN == 1 resolve on the very first press.
    // -------------------------------------------------------------------------
    always_comb begin
        pos            = (state_q == ST_LOCKED) ? '0 : cnt_q;
        expected_digit = code_q[pos*IDX_W +: IDX_W];
        digit_bad      = !one_hot || (digit_val != expected_digit);
        mismatch_acc   = ((state_q == ST_LOCKED) ? 1'b0 : mis_q) | digit_bad;
        last_digit     = (pos == CNT_W'(CODE_LEN - 1));
        // Expiry is the TIMEOUT_CYCLES-th idle clock; a press in that same
        // cycle takes priority because events are checked first below.
        idle_expired   = (tmr_q >= TMR_W'(TIMEOUT_CYCLES - 1));
        lock_done      = (tmr_q >= TMR_W'(LOCKOUT_CYCLES - 1));
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_n  = state_q;
        cnt_n    = cnt_q;
        fail_n   = fail_q;
        tmr_n    = tmr_q;
        mis_n    = mis_q;
        code_n   = code_q;
        shadow_n = shadow_q;
        commit   = 1'b0;

        unique case (state_q)
            ST_LOCKED, ST_ENTRY: begin
                if (any_event) begin
                    tmr_n = '0;
                    if (last_digit) begin
                        cnt_n = '0;
                        mis_n = 1'b0;
                        if (!mismatch_acc) begin
                            state_n = ST_UNLOCKED;
                            fail_n  = '0;
                        end else if (fail_q >= FAIL_W'(MAX_TRIES - 1)) begin
                            state_n = ST_LOCKOUT;
                            fail_n  = FAIL_W'(MAX_TRIES);
                        end else begin
                            state_n = ST_LOCKED;
                            fail_n  = fail_q + FAIL_W'(1);
                        end
                    end else begin
                        state_n = ST_ENTRY;
                        cnt_n   = pos + CNT_W'(1);
                        mis_n   = mismatch_acc;
                    end
                end else if (state_q == ST_ENTRY) begin
                    if (idle_expired) begin
                        // Abandoned entry is not counted as a failure.
                        state_n = ST_LOCKED;
                        cnt_n   = '0;
                        mis_n   = 1'b0;
                        tmr_n   = '0;
                    end else begin
                        tmr_n = tmr_q + TMR_W'(1);
                    end
                end else begin
                    tmr_n = '0;
                end
            end

            ST_UNLOCKED: begin
                tmr_n = '0;
                if (relock) begin
                    state_n = ST_LOCKED;
                end else if (prog) begin
                    state_n  = ST_PROGRAM;
                    cnt_n    = '0;
                    shadow_n = code_q;
                end
            end

            ST_PROGRAM: begin
                if (relock) begin
                    state_n = ST_LOCKED;
                    cnt_n   = '0;
                    tmr_n   = '0;
                end else if (any_event) begin
                    tmr_n = '0;
                    if (!one_hot) begin
                        state_n = ST_UNLOCKED;
                        cnt_n   = '0;
                    end else begin
                        shadow_n[cnt_q*IDX_W +: IDX_W] = digit_val;
                        if (cnt_q == CNT_W'(CODE_LEN - 1)) begin
                            code_n  = shadow_n;
                            commit  = 1'b1;
                            state_n = ST_UNLOCKED;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_q + CNT_W'(1);
                        end
                    end
                end else if (idle_expired) begin
                    state_n = ST_UNLOCKED;
                    cnt_n   = '0;
                    tmr_n   = '0;
                end else begin
                    tmr_n = tmr_q + TMR_W'(1);
                end
            end

            ST_LOCKOUT: begin
                if (lock_done) begin
                    state_n = ST_LOCKED;
                    fail_n  = '0;
                    tmr_n   = '0;
                end else begin
                    tmr_n = tmr_q + TMR_W'(1);
                end
            end

            default: begin
                state_n = ST_LOCKED;
                cnt_n   = '0;
                tmr_n   = '0;
                mis_n   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOCKED;
            cnt_q    <= '0;
            fail_q   <= '0;
            tmr_q    <= '0;
            mis_q    <= 1'b0;
            // NOTE: the code and shadow registers are reset on purpose so a
            // reset always discards a reprogrammed code and restores the default.
            code_q   <= DEFAULT_CODE;
            shadow_q <= DEFAULT_CODE;
            unlocked <= 1'b0;
            lockout  <= 1'b0;
            led      <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            fail_q   <= fail_n;
            tmr_q    <= tmr_n;
            mis_q    <= mis_n;
            code_q   <= code_n;
            shadow_q <= shadow_n;
            unlocked <= (state_n == ST_UNLOCKED);
            lockout  <= (state_n == ST_LOCKOUT);
            // Status codes 0..4 coincide with the state encoding.
            led      <= commit ? LED_COMMIT : {1'b0, state_n};
        end
    end

    assign state     = state_q;
    assign digit_cnt = cnt_q;
    assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_digital_lock_param.sv
// -----------------------------------------------------------------------------
// tb_digital_lock_param
//
// Directed testbench for digital_lock_param with TIMEOUT_CYCLES=32 and
// LOCKOUT_CYCLES=16, all other parameters at their defaults (code 0,1,2,3).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge that consumed them.
// -----------------------------------------------------------------------------
module tb_digital_lock_param;

    logic       clk;
    logic       rst_n;
    logic [3:0] button;
    logic       relock;
    logic       prog;
    logic       unlocked;
    logic       lockout;
    logic [2:0] state;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;
    logic [3:0] led;

    int n_cmp = 0;
    int n_bad = 0;

    digital_lock_param #(
        .NUM_BUTTONS   (4),
        .CODE_LEN      (4),
        .MAX_TRIES     (3),
        .LOCKOUT_CYCLES(16),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .button   (button),
        .relock   (relock),
        .prog     (prog),
        .unlocked (unlocked),
        .lockout  (lockout),
        .state    (state),
        .digit_cnt(digit_cnt),
        .fail_cnt (fail_cnt),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One clock: drive on the falling edge, sample just after the rising edge.
    task automatic step(input logic [3:0] b, input logic r, input logic p);
        @(negedge clk);
        button = b;
        relock = r;
        prog   = p;
        @(posedge clk);
        #1;
        button = '0;
        relock = 1'b0;
        prog   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic enter(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        step(a, 1'b0, 1'b0);
        step(b, 1'b0, 1'b0);
        step(c, 1'b0, 1'b0);
        step(d, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        button = '0;
        relock = 1'b0;
        prog   = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_state",    state,     0);
        check("rst_digit",    digit_cnt, 0);
        check("rst_fail",     fail_cnt,  0);
        check("rst_unlocked", unlocked,  0);
        check("rst_lockout",  lockout,   0);
        check("rst_led",      led,       0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Correct code 0,1,2,3
        step(4'b0001, 1'b0, 1'b0);
        check("t1_entry_state", state,     1);
        check("t1_entry_digit", digit_cnt, 1);
        check("t1_entry_led",   led,       1);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        check("t1_pre_unlocked", unlocked, 0);
        step(4'b1000, 1'b0, 1'b0);
        check("t1_unlocked", unlocked,  1);
        check("t1_state",    state,     2);
        check("t1_fail",     fail_cnt,  0);
        check("t1_led",      led,       2);
        check("t1_digit",    digit_cnt, 0);
        step(4'b0000, 1'b1, 1'b0);
        check("t1_relock_state",    state,    0);
        check("t1_relock_unlocked", unlocked, 0);

        // 2. Three wrong attempts -> lockout
        enter(4'b0001, 4'b0010, 4'b0100, 4'b0100);
        check("t2_fail1",  fail_cnt, 1);
        check("t2_state1", state,    0);
        enter(4'b0001, 4'b0010, 4'b0100, 4'b0100);
        check("t2_fail2",  fail_cnt, 2);
        check("t2_state2", state,    0);
        enter(4'b0001, 4'b0010, 4'b0100, 4'b0100);
        check("t2_lockout", lockout,  1);
        check("t2_state3",  state,    4);
        check("t2_fail3",   fail_cnt, 3);
        check("t2_led3",    led,      4);
        // Correct code during lockout is ignored (4 of the 16 clocks).
        enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        check("t2_ignored_state",    state,    4);
        check("t2_ignored_unlocked", unlocked, 0);
        idle(11);
        check("t2_clk15_state", state, 4);
        idle(1);
        check("t2_exit_state",   state,    0);
        check("t2_exit_fail",    fail_cnt, 0);
        check("t2_exit_lockout", lockout,  0);
        enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        check("t2_unlock", unlocked, 1);
        step(4'b0000, 1'b1, 1'b0);

        // 3. Inter-digit timeout
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        idle(31);
        check("t3_idle31_state", state,     1);
        check("t3_idle31_digit", digit_cnt, 2);
        idle(1);
        check("t3_timeout_state", state,     0);
        check("t3_timeout_digit", digit_cnt, 0);
        check("t3_timeout_fail",  fail_cnt,  0);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        idle(31);
        step(4'b0100, 1'b0, 1'b0);
        check("t3_race_state", state,     1);
        check("t3_race_digit", digit_cnt, 3);
        step(4'b1000, 1'b0, 1'b0);
        check("t3_race_unlock", unlocked, 1);

        // 4. Reprogram to 3,3,1,0
        step(4'b0000, 1'b0, 1'b1);
        check("t4_prog_state", state,     3);
        check("t4_prog_led",   led,       3);
        check("t4_prog_digit", digit_cnt, 0);
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        check("t4_prog_digit3", digit_cnt, 3);
        step(4'b0001, 1'b0, 1'b0);
        check("t4_commit_led",   led,   5);
        check("t4_commit_state", state, 2);
        idle(1);
        check("t4_after_led", led, 2);
        step(4'b0000, 1'b1, 1'b0);
        check("t4_relock", state, 0);
        enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        check("t4_oldcode_fail",     fail_cnt, 1);
        check("t4_oldcode_unlocked", unlocked, 0);
        enter(4'b1000, 4'b1000, 4'b0010, 4'b0001);
        check("t4_newcode_unlocked", unlocked, 1);
        check("t4_newcode_fail",     fail_cnt, 0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        check("t4_mid_state", state, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t4_async_rst_state", state,     0);
        check("t4_async_rst_digit", digit_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        check("t4_default_restored", unlocked, 1);
        step(4'b0000, 1'b1, 1'b0);

        // 5. Multi-hot handling and relock/prog priority
        enter(4'b0011, 4'b0010, 4'b0100, 4'b1000);
        check("t5_multihot_fail",  fail_cnt, 1);
        check("t5_multihot_state", state,    0);
        enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        check("t5_unlock", unlocked, 1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b0);
        check("t5_prog_digit", digit_cnt, 1);
        step(4'b0011, 1'b0, 1'b0);
        check("t5_abort_state", state,     2);
        check("t5_abort_digit", digit_cnt, 0);
        check("t5_abort_led",   led,       2);
        step(4'b0000, 1'b1, 1'b0);
        enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        check("t5_code_intact", unlocked, 1);
        step(4'b0000, 1'b1, 1'b1);
        check("t5_relock_wins_state",    state,    0);
        check("t5_relock_wins_unlocked", unlocked, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
